// File: rtl/vga_pkg.sv
// Shared raster timing constants for the pixel-clock domain (640x480@60 by default)
// plus the bundle of registered control outputs used by the timing generator.
package vga_pkg;

    localparam int   H_ACTIVE = 640;
    localparam int   H_FP     = 16;
    localparam int   H_SYNC   = 96;
    localparam int   H_BP     = 48;
    localparam int   V_ACTIVE = 480;
    localparam int   V_FP     = 10;
    localparam int   V_SYNC   = 2;
    localparam int   V_BP     = 33;
    localparam logic HS_POL   = 1'b0;
    localparam logic VS_POL   = 1'b0;
    localparam int   CW       = 12;

    localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic data_en;
        logic line_start;
        logic frame_start;
        logic vblank;
    } vga_ctl_t;

    // Idle control word: syncs at their inactive level, every strobe low.
    function automatic vga_ctl_t vga_ctl_idle(input logic hs_pol, input logic vs_pol);
        vga_ctl_t c;
        c       = '0;
        c.hsync = ~hs_pol;
        c.vsync = ~vs_pol;
        return c;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on i_inc and returns to 0 at terminal count;
// i_clr forces the origin synchronously.
module vga_axis_counter #(
    parameter int CW    = 12,
    parameter int TOTAL = 800
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_cnt
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: chained H/V counters, registered decode of
// sync/data-enable/strobes, and a 9-bit frame counter. All outputs share one clk of latency.
module vga_timing_gen #(
    parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_pkg::H_FP,
    parameter int   H_SYNC   = vga_pkg::H_SYNC,
    parameter int   H_BP     = vga_pkg::H_BP,
    parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_pkg::V_FP,
    parameter int   V_SYNC   = vga_pkg::V_SYNC,
    parameter int   V_BP     = vga_pkg::V_BP,
    parameter logic HS_POL   = vga_pkg::HS_POL,
    parameter logic VS_POL   = vga_pkg::VS_POL,
    parameter int   CW       = vga_pkg::CW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          data_en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank,
    output logic [8:0]    frame
);

    import vga_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_width
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end
    if (H_TOT > (1 << CW) || V_TOT > (1 << CW)) begin : g_bad_total
        $error("vga_timing_gen: H/V totals do not fit in CW-bit counters");
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
    localparam logic [CW-1:0] H_ACT_L  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT_L  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] w_hcnt;
    logic [CW-1:0] w_vcnt;
    logic          w_h_wrap;
    vga_ctl_t      w_ctl;

    vga_ctl_t      r_ctl;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [8:0]    r_frame;

    assign w_h_wrap = en && (w_hcnt == H_LAST);

    vga_axis_counter #(.CW(CW), .TOTAL(H_TOT)) u_hcnt (
        .clk    (clk),
        .resetn (resetn),
        .i_clr  (~en),
        .i_inc  (en),
        .o_cnt  (w_hcnt)
    );

    vga_axis_counter #(.CW(CW), .TOTAL(V_TOT)) u_vcnt (
        .clk    (clk),
        .resetn (resetn),
        .i_clr  (~en),
        .i_inc  (w_h_wrap),
        .o_cnt  (w_vcnt)
    );

    always_comb begin
        w_ctl             = vga_ctl_idle(HS_POL, VS_POL);
        w_ctl.data_en     = (w_hcnt < H_ACT_L) && (w_vcnt < V_ACT_L);
        w_ctl.hsync       = ((w_hcnt >= HS_START) && (w_hcnt < HS_END)) ? HS_POL : ~HS_POL;
        w_ctl.vsync       = ((w_vcnt >= VS_START) && (w_vcnt < VS_END)) ? VS_POL : ~VS_POL;
        w_ctl.line_start  = (w_hcnt == '0);
        w_ctl.frame_start = (w_hcnt == '0) && (w_vcnt == '0);
        w_ctl.vblank      = (w_vcnt >= V_ACT_L);
    end

    // frame advances on the same edge that raises frame_start, so the new count
    // is visible alongside the pulse; it survives en-low but not resetn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ctl   <= vga_ctl_idle(HS_POL, VS_POL);
            r_x     <= '0;
            r_y     <= '0;
            r_frame <= '0;
        end else if (!en) begin
            r_ctl   <= vga_ctl_idle(HS_POL, VS_POL);
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_ctl   <= w_ctl;
            r_x     <= w_hcnt;
            r_y     <= w_vcnt;
            if (w_ctl.frame_start) begin
                r_frame <= r_frame + 9'd1;
            end
        end
    end

    assign hsync       = r_ctl.hsync;
    assign vsync       = r_ctl.vsync;
    assign data_en     = r_ctl.data_en;
    assign line_start  = r_ctl.line_start;
    assign frame_start = r_ctl.frame_start;
    assign vblank      = r_ctl.vblank;
    assign x           = r_x;
    assign y           = r_y;
    assign frame       = r_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster (8x6 totals) so whole frames and the
// 9-bit frame wrap fit in a short run; a second instance has inverted sync polarity.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
    localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
    localparam int CW = 4;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0, resetn = 1'b0, en = 1'b0;
    logic hsync, vsync, data_en, line_start, frame_start, vblank;
    logic [CW-1:0] x, y;
    logic [8:0] frame;
    logic p_hsync, p_vsync, p_data_en, p_line_start, p_frame_start, p_vblank;
    logic [CW-1:0] p_x, p_y;
    logic [8:0] p_frame;

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                     .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)) dut (
        .clk(clk), .resetn(resetn), .en(en), .hsync(hsync), .vsync(vsync),
        .data_en(data_en), .x(x), .y(y), .line_start(line_start),
        .frame_start(frame_start), .vblank(vblank), .frame(frame));

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                     .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)) dut_p (
        .clk(clk), .resetn(resetn), .en(en), .hsync(p_hsync), .vsync(p_vsync),
        .data_en(p_data_en), .x(p_x), .y(p_y), .line_start(p_line_start),
        .frame_start(p_frame_start), .vblank(p_vblank), .frame(p_frame));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: position = enabled cycles since origin, raster derived by div/mod.
    int         m_pos, m_x, m_y;
    logic [8:0] m_frame;
    logic       m_de, m_hs, m_vs, m_ls, m_fs, m_vb;

    function automatic void model_idle();
        m_x = 0; m_y = 0; m_de = 0; m_hs = 0; m_vs = 0; m_ls = 0; m_fs = 0; m_vb = 0;
        m_pos = 0;
    endfunction

    function automatic void model_reset();
        model_idle();
        m_frame = '0;
    endfunction

    function automatic void model_edge();
        int h, v;
        if (!en) begin
            model_idle();
            return;
        end
        h = m_pos % HT;
        v = (m_pos / HT) % VT;
        m_x  = h;
        m_y  = v;
        m_de = (h < HA) && (v < VA);
        m_hs = (h >= HA + HF) && (h < HA + HF + HSW);
        m_vs = (v >= VA + VF) && (v < VA + VF + VSW);
        m_ls = (h == 0);
        m_fs = (m_pos % FT) == 0;
        m_vb = (v >= VA);
        if (m_fs) m_frame = m_frame + 9'd1;
        m_pos++;
    endfunction

    function automatic void check_all();
        check("x", x, m_x);
        check("y", y, m_y);
        check("data_en", data_en, m_de);
        check("hsync", hsync, !m_hs);
        check("vsync", vsync, !m_vs);
        check("line_start", line_start, m_ls);
        check("frame_start", frame_start, m_fs);
        check("vblank", vblank, m_vb);
        check("frame", frame, m_frame);
        check("pol_hsync", p_hsync, m_hs);
        check("pol_vsync", p_vsync, m_vs);
        check("pol_rest", {p_data_en, p_line_start, p_frame_start, p_vblank, p_x, p_y, p_frame},
              {m_de, m_ls, m_fs, m_vb, CW'(m_x), CW'(m_y), m_frame});
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        en     = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        resetn = 1'b1;
    endtask

    typedef struct {
        int   px, py;
        logic de, hs, vs, vb, ls, fs;
    } vec_t;
    vec_t tbl[12];

    int   hs_cnt, de_cnt, vs_cnt, run_len, last_fall;
    logic prev_hs, prev_vs;

    initial begin
        tbl[0]  = '{0, 0, 1, 0, 0, 0, 1, 1};
        tbl[1]  = '{3, 0, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{4, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{5, 0, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{6, 1, 0, 1, 0, 0, 0, 0};
        tbl[5]  = '{7, 1, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 2, 1, 0, 0, 0, 1, 0};
        tbl[7]  = '{3, 2, 1, 0, 0, 0, 0, 0};
        tbl[8]  = '{2, 3, 0, 0, 0, 1, 0, 0};
        tbl[9]  = '{0, 4, 0, 0, 1, 1, 1, 0};
        tbl[10] = '{5, 4, 0, 1, 1, 1, 0, 0};
        tbl[11] = '{7, 5, 0, 0, 0, 1, 0, 0};

        // Reset state and first-cycle alignment after enable.
        do_reset();
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_pol_hsync", p_hsync, 0);
        check("rst_strobes", {data_en, line_start, frame_start, vblank}, 0);
        check("rst_xy_frame", {x, y, frame}, 0);
        en = 1'b1;
        cyc();
        check("start_xy", {x, y}, 0);
        check("start_strobes", {data_en, line_start, frame_start}, 3'b111);
        check("start_frame", frame, 1);

        // Fixed raster positions.
        foreach (tbl[i]) begin
            do_reset();
            en = 1'b1;
            run(tbl[i].py * HT + tbl[i].px + 1);
            check($sformatf("tbl%0d_xy", i), {x, y}, {CW'(tbl[i].px), CW'(tbl[i].py)});
            check($sformatf("tbl%0d_de", i), data_en, tbl[i].de);
            check($sformatf("tbl%0d_hsync", i), hsync, !tbl[i].hs);
            check($sformatf("tbl%0d_vsync", i), vsync, !tbl[i].vs);
            check($sformatf("tbl%0d_vblank", i), vblank, tbl[i].vb);
            check($sformatf("tbl%0d_ls", i), line_start, tbl[i].ls);
            check($sformatf("tbl%0d_fs", i), frame_start, tbl[i].fs);
        end

        // Two full frames: pulse widths, positions and totals.
        do_reset();
        en = 1'b1;
        hs_cnt = 0; de_cnt = 0; vs_cnt = 0; run_len = 0; last_fall = -1;
        prev_hs = 1'b1; prev_vs = 1'b1;
        for (int c = 0; c < 2 * FT; c++) begin
            cyc();
            if (!hsync) begin hs_cnt++; run_len++; end
            if (data_en) de_cnt++;
            if (!vsync) vs_cnt++;
            if (prev_hs && !hsync) begin
                check("hs_fall_x", x, HA + HF);
                if (last_fall >= 0) check("hs_period", c - last_fall, HT);
                last_fall = c;
            end
            if (!prev_hs && hsync) begin
                check("hs_width", run_len, HSW);
                run_len = 0;
            end
            if (prev_vs && !vsync) check("vs_fall_pos", {x, y}, {CW'(0), CW'(VA + VF)});
            prev_hs = hsync;
            prev_vs = vsync;
        end
        check("hs_total", hs_cnt, 2 * VT * HSW);
        check("de_total", de_cnt, 2 * HA * VA);
        check("vs_total", vs_cnt, 2 * VSW * HT);
        check("two_frame_count", frame, 2);

        // Enable dropped mid-line for 5 clocks.
        do_reset();
        en = 1'b1;
        run(2 * HT + 3 + 1);
        check("pre_drop_xy", {x, y}, {CW'(3), CW'(2)});
        en = 1'b0;
        run(5);
        check("drop_xy", {x, y, data_en}, 0);
        check("drop_frame", frame, 1);
        en = 1'b1;
        cyc();
        check("restart_xy", {x, y}, 0);
        check("restart_fs", {frame_start, data_en}, 2'b11);
        check("restart_frame", frame, 2);

        // Asynchronous reset at the last pixel of the frame.
        do_reset();
        en = 1'b1;
        run(FT - 1);
        check("pre_rst_xy", {x, y}, {CW'(HT - 2), CW'(VT - 1)});
        #2 resetn = 1'b0;
        model_reset();
        #1;
        check("async_rst_frame", frame, 0);
        check("async_rst_strobes", {line_start, frame_start, data_en, vblank}, 0);
        check("async_rst_syncs", {hsync, vsync, p_hsync, p_vsync}, 4'b1100);
        check_all();
        @(negedge clk);
        check_all();
        resetn = 1'b1;
        cyc();
        check("post_rst_frame", frame, 1);

        // 512 frames: frame counter wraps 511 -> 0.
        do_reset();
        en = 1'b1;
        cyc();
        run(510 * FT);
        check("frame_511", {frame_start, frame}, {1'b1, 9'd511});
        run(FT);
        check("frame_wrap", {frame_start, frame}, {1'b1, 9'd0});
        check("pol_frame_wrap", p_frame, 0);

        // Random enable / reset activity against the model.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                #2 resetn = 1'b0;
                model_reset();
                #1 check_all();
                @(negedge clk);
                resetn = 1'b1;
            end
            en = ($urandom_range(0, 63) != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
